// File: rtl/bitvert_pkg.sv
// Shared types and constants for the BitVert bit-plane dot-product datapath.
package bitvert_pkg;

    localparam int unsigned ACT_WIDTH  = 8;
    localparam int unsigned VEC_LENGTH = 8;
    localparam int unsigned W_BITS     = 8;
    localparam int unsigned NUM_SLOT   = 4;
    localparam int unsigned ACC_WIDTH  = 20;
    localparam int unsigned SEL_WIDTH  = 3;
    localparam int unsigned CNT_WIDTH  = $clog2(W_BITS);

    typedef logic signed [ACT_WIDTH-1:0] act_t;
    typedef logic        [SEL_WIDTH-1:0] sel_t;
    typedef logic signed [ACC_WIDTH-1:0] acc_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

endpackage

// File: rtl/bitvert_plane_sum.sv
// Combinational partial sum of one bit plane: slot mux, adder tree and
// inverted-plane recovery (total minus selected).
module bitvert_plane_sum
    import bitvert_pkg::*;
(
    input  logic [VEC_LENGTH*ACT_WIDTH-1:0] act,
    input  logic [NUM_SLOT*SEL_WIDTH-1:0]   sel,
    input  logic [NUM_SLOT-1:0]             val,
    input  logic                            skip_bit_1,
    output logic [ACC_WIDTH-1:0]            p_c
);

    act_t act_arr [VEC_LENGTH];
    acc_t sel_sum;
    acc_t tot_sum;

    always_comb begin
        for (int i = 0; i < int'(VEC_LENGTH); i++) begin
            act_arr[i] = act_t'(act[i*ACT_WIDTH +: ACT_WIDTH]);
        end
    end

    // Sum of selected slots and sum of every activation
    always_comb begin
        sel_sum = '0;
        tot_sum = '0;
        for (int i = 0; i < int'(VEC_LENGTH); i++) begin
            tot_sum = tot_sum + acc_t'(act_arr[i]);
        end
        for (int k = 0; k < int'(NUM_SLOT); k++) begin
            if (val[k]) begin
                sel_sum = sel_sum + acc_t'(act_arr[sel_t'(sel[k*SEL_WIDTH +: SEL_WIDTH])]);
            end
        end
    end

    assign p_c = skip_bit_1 ? (tot_sum - sel_sum) : sel_sum;

endmodule

// File: rtl/bitvert_pe_accum.sv
// BitVert PE accumulator: consumes MSB-first bit-plane schedules and
// shift-accumulates a signed 8-element dot product.
module bitvert_pe_accum
    import bitvert_pkg::*;
(
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [VEC_LENGTH*ACT_WIDTH-1:0] act_in,
    input  logic                            plane_vld,
    input  logic [NUM_SLOT*SEL_WIDTH-1:0]   sel,
    input  logic [NUM_SLOT-1:0]             val,
    input  logic                            skip_bit_1,
    output logic                            busy,
    output logic [ACC_WIDTH-1:0]            result,
    output logic                            out_valid
);

    localparam logic [CNT_WIDTH-1:0] CNT_TOP = CNT_WIDTH'(W_BITS - 1);

    state_t                          state_q,     state_d;
    logic [CNT_WIDTH-1:0]            cnt_q,       cnt_d;
    acc_t                            acc_q,       acc_d;
    logic [VEC_LENGTH*ACT_WIDTH-1:0] act_q,       act_d;
    logic [ACC_WIDTH-1:0]            result_q,    result_d;
    logic                            out_valid_q, out_valid_d;
    logic                            busy_q,      busy_d;
    acc_t                            plane_p;

    bitvert_plane_sum u_plane_sum (
        .act        (act_q),
        .sel        (sel),
        .val        (val),
        .skip_bit_1 (skip_bit_1),
        .p_c        (plane_p)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_TOP;
            acc_q       <= '0;
            act_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            act_q       <= act_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    // Next state: the sign plane seeds the accumulator negated, later planes shift in
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        act_d       = act_q;
        result_d    = result_q;
        out_valid_d = 1'b0;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    act_d   = act_in;
                    acc_d   = '0;
                    cnt_d   = CNT_TOP;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (plane_vld) begin
                    if (cnt_q == CNT_TOP) begin
                        acc_d = -plane_p;
                    end else begin
                        acc_d = (acc_q <<< 1) + plane_p;
                    end
                    if (cnt_q == '0) begin
                        state_d     = IDLE;
                        busy_d      = 1'b0;
                        out_valid_d = 1'b1;
                        result_d    = acc_d;
                    end else begin
                        cnt_d = cnt_q - CNT_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy      = busy_q;
    assign result    = result_q;
    assign out_valid = out_valid_q;

endmodule
